md_unit: RTL and testbench

//  Multi-cycle multiply/divide responder that owns the HI/LO pair. E issues one op per request and

---
 rtl/md_unit_if.sv | 23 ++
 rtl/md_unit.sv | 170 +++++++++++++++++
 tb/tb_md_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// E-stage <-> multiply/divide unit request/response bundle.
// E drives the request side; the unit returns HI/LO and its status.
interface md_unit_if;
  logic        md_valid;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_flush;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_busy;
  logic        md_done;

  modport master (
    output md_valid, md_op, md_a, md_b, md_flush,
    input  md_hi, md_lo, md_busy, md_done
  );

  modport slave (
    input  md_valid, md_op, md_a, md_b, md_flush,
    output md_hi, md_lo, md_busy, md_done
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: fixed-latency multiply/accumulate
// and a 33-cycle radix-2 restoring divider (32 iterations plus sign fixup).
module md_unit #(
  parameter int MUL_CYCLES = 3
) (
  input logic       Clk,
  input logic       reset,
  md_unit_if.slave  md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3, OP_DIVU  = 4'd4,
                         OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MUL   = 4'd7, OP_MADD  = 4'd8,
                         OP_MADDU = 4'd9, OP_MSUB  = 4'd10, OP_MSUBU = 4'd11;

  state_t      state_q, state_nxt;
  logic [5:0]  cnt_q, cnt_nxt;
  logic        busy_q, done_q, done_nxt;
  logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;
  logic        ld_op;

  logic [3:0]  op_p0;
  logic [31:0] a_p0, b_p0;
  logic [31:0] rem_p1, quo_p1, dvs_p1;
  logic [32:0] rem_sh, trial;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MUL) || (op == OP_DIV) ||
           (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic [31:0] magnitude(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  // 64-bit product, optionally folded into the current HI/LO with wraparound.
  function automatic logic [63:0] mul_acc(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    logic signed [63:0] sa, sb;
    logic [63:0] prod;
    sa = is_signed_op(op) ? {{32{a[31]}}, a} : {32'd0, a};
    sb = is_signed_op(op) ? {{32{b[31]}}, b} : {32'd0, b};
    prod = sa * sb;
    case (op)
      OP_MADD, OP_MADDU: return acc + prod;
      OP_MSUB, OP_MSUBU: return acc - prod;
      default:           return prod;
    endcase
  endfunction

  // Final step: restore signs, or apply the divide-by-zero convention.
  function automatic logic [63:0] div_fixup(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] quo,
                                            input logic [31:0] rem);
    logic sgn;
    logic [31:0] q, r;
    sgn = is_signed_op(op);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = (sgn && (a[31] ^ b[31])) ? (32'd0 - quo) : quo;
    r = (sgn && a[31]) ? (32'd0 - rem) : rem;
    return {r, q};
  endfunction

  assign rem_sh = {rem_p1, quo_p1[31]};
  assign trial  = rem_sh - {1'b0, dvs_p1};

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    done_nxt  = 1'b0;
    ld_op     = 1'b0;
    if (md.md_flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md.md_valid) begin
            case (md.md_op)
              OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                state_nxt = S_MUL;
                cnt_nxt   = 6'd0;
                ld_op     = 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                state_nxt = S_DIV;
                cnt_nxt   = 6'd0;
                ld_op     = 1'b1;
              end
              OP_MTHI: hi_nxt = md.md_a;
              OP_MTLO: lo_nxt = md.md_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == 6'(MUL_CYCLES - 1)) begin
            {hi_nxt, lo_nxt} = mul_acc(op_p0, a_p0, b_p0, {hi_q, lo_q});
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = 6'd0;
          end else begin
            cnt_nxt = cnt_q + 6'd1;
          end
        end
        S_DIV: begin
          if (cnt_q == 6'd32) begin
            {hi_nxt, lo_nxt} = div_fixup(op_p0, a_p0, b_p0, quo_p1, rem_p1);
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = 6'd0;
          end else begin
            cnt_nxt = cnt_q + 6'd1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= done_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
    end
  end

  // p0: operands captured at start; p1: divider remainder/quotient iteration
  always_ff @(posedge Clk) begin
    if (ld_op) begin
      op_p0  <= md.md_op;
      a_p0   <= md.md_a;
      b_p0   <= md.md_b;
      rem_p1 <= 32'd0;
      quo_p1 <= magnitude(is_signed_op(md.md_op), md.md_a);
      dvs_p1 <= magnitude(is_signed_op(md.md_op), md.md_b);
    end else if (state_q == S_DIV && cnt_q < 6'd32) begin
      if (!trial[32]) begin
        rem_p1 <= trial[31:0];
        quo_p1 <= {quo_p1[30:0], 1'b1};
      end else begin
        rem_p1 <= rem_sh[31:0];
        quo_p1 <= {quo_p1[30:0], 1'b0};
      end
    end
  end

  assign md.md_hi   = hi_q;
  assign md.md_lo   = lo_q;
  assign md.md_busy = busy_q;
  assign md.md_done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: multiply/accumulate, divide corner cases,
// flush, busy-time requests and asynchronous reset.
module tb_md_unit;
  logic Clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   nb;

  md_unit_if bus();

  md_unit #(.MUL_CYCLES(3)) dut (
    .Clk   (Clk),
    .reset (reset),
    .md    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request for one cycle, return at the next negedge.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.md_valid = 1'b1;
    bus.md_op    = op;
    bus.md_a     = a;
    bus.md_b     = b;
    @(negedge Clk);
    bus.md_valid = 1'b0;
    bus.md_op    = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.md_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start_op(op, a, b);
    wait_idle(n);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    chk({tag, "_done"}, {31'd0, bus.md_done}, 32'd1);
    chk({tag, "_hi"}, bus.md_hi, exp_hi);
    chk({tag, "_lo"}, bus.md_lo, exp_lo);
    @(negedge Clk);
    chk({tag, "_done_drop"}, {31'd0, bus.md_done}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.md_valid = 1'b0;
    bus.md_op    = 4'd0;
    bus.md_a     = 32'd0;
    bus.md_b     = 32'd0;
    bus.md_flush = 1'b0;
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    chk("rst_hi", bus.md_hi, 32'd0);
    chk("rst_lo", bus.md_lo, 32'd0);
    chk("rst_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.md_done}, 32'd0);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mul", 4'd7, 32'd3, 32'hFFFF_FFFC, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    start_op(4'd5, 32'd5, 32'd0);
    chk("mthi_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("mthi_hi", bus.md_hi, 32'd5);
    start_op(4'd6, 32'd7, 32'd0);
    chk("mtlo_lo", bus.md_lo, 32'd7);
    chk("mtlo_done", {31'd0, bus.md_done}, 32'd0);
    run_op("madd", 4'd8, 32'd2, 32'd3, 3, 32'd5, 32'd13);
    start_op(4'd5, 32'd5, 32'd0);
    start_op(4'd6, 32'd7, 32'd0);
    run_op("msub", 4'd10, 32'd2, 32'd3, 3, 32'd5, 32'd1);
    start_op(4'd5, 32'd0, 32'd0);
    start_op(4'd6, 32'd1, 32'd0);
    run_op("msubu_wrap", 4'd11, 32'd1, 32'd2, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_zero", 4'd4, 32'd7, 32'd0, 33, 32'd7, 32'hFFFF_FFFF);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("divu", 4'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    // Flush in the tenth busy cycle of a divide.
    start_op(4'd5, 32'h11, 32'd0);
    start_op(4'd6, 32'h22, 32'd0);
    start_op(4'd3, 32'd50, 32'd5);
    repeat (9) @(negedge Clk);
    chk("flush_pre_busy", {31'd0, bus.md_busy}, 32'd1);
    bus.md_flush = 1'b1;
    @(negedge Clk);
    bus.md_flush = 1'b0;
    chk("flush_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("flush_done", {31'd0, bus.md_done}, 32'd0);
    chk("flush_hi", bus.md_hi, 32'h11);
    chk("flush_lo", bus.md_lo, 32'h22);
    run_op("post_flush_mult", 4'd1, 32'd6, 32'd7, 3, 32'd0, 32'd42);

    // Requests while busy are ignored, including mthi.
    start_op(4'd4, 32'd100, 32'd7);
    start_op(4'd5, 32'h99, 32'd0);
    start_op(4'd1, 32'd9, 32'd9);
    wait_idle(nb);
    chk("busyreq_cycles", 32'(nb), 32'd31);
    chk("busyreq_done", {31'd0, bus.md_done}, 32'd1);
    chk("busyreq_hi", bus.md_hi, 32'd2);
    chk("busyreq_lo", bus.md_lo, 32'd14);
    @(negedge Clk);
    chk("busyreq_idle", {31'd0, bus.md_busy}, 32'd0);

    // Flush coinciding with a start suppresses it.
    bus.md_flush = 1'b1;
    start_op(4'd5, 32'hAA, 32'd0);
    chk("flush_mthi_hi", bus.md_hi, 32'd2);
    start_op(4'd1, 32'd4, 32'd4);
    bus.md_flush = 1'b0;
    chk("flush_start_busy", {31'd0, bus.md_busy}, 32'd0);
    @(negedge Clk);
    chk("flush_start_lo", bus.md_lo, 32'd14);

    // Asynchronous reset between edges in the middle of a divide.
    start_op(4'd3, 32'd1000, 32'd3);
    repeat (5) @(negedge Clk);
    #2 reset = 1'b1;
    #1;
    chk("areset_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("areset_hi", bus.md_hi, 32'd0);
    chk("areset_lo", bus.md_lo, 32'd0);
    chk("areset_done", {31'd0, bus.md_done}, 32'd0);
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    chk("areset_stay_idle", {31'd0, bus.md_busy}, 32'd0);
    run_op("post_reset_multu", 4'd2, 32'h0001_0000, 32'h0001_0000, 3, 32'd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
